// File: rtl/candidate_pkg.sv
// rtl/candidate_pkg.sv - shared types and constants for the candidate issuer
package candidate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam int GROUP_W = 3;

    localparam logic [5:0] NOW_FULL = 6'd4;
    localparam logic [5:0] NOW_TWO  = 6'd3;
    localparam logic [5:0] NOW_ONE  = 6'd2;
    localparam logic [5:0] NOW_NONE = 6'd0;

    localparam logic [1:0] MODE_ALL = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_MAJ = 2'b11;

    // Group code from the number of job bits not yet issued.
    function automatic logic [5:0] group_code(input logic [5:0] remaining);
        if (remaining >= 6'd3)      return NOW_FULL;
        else if (remaining == 6'd2) return NOW_TWO;
        else if (remaining == 6'd1) return NOW_ONE;
        else                        return NOW_NONE;
    endfunction

endpackage

// File: rtl/issue_bit_buffer.sv
// rtl/issue_bit_buffer.sv - bit buffer written serially, read as 3-bit groups
module issue_bit_buffer
    import candidate_pkg::*;
#(
    parameter int MAX_LEN = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       wr_en,
    input  logic       wr_bit,
    input  logic       rd_adv,
    output logic [5:0] wr_ptr,
    output logic [4:0] grp_ptr,
    output logic [2:0] grp_bits
);

    logic [MAX_LEN-1:0] mem;

    // Reads shift the buffer down so the oldest group always sits at bit 0;
    // zeros shifted in give the cleared tail bits of a short final group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem     <= '0;
            wr_ptr  <= '0;
            grp_ptr <= '0;
        end else if (clear) begin
            mem     <= '0;
            wr_ptr  <= '0;
            grp_ptr <= '0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (wr_ptr == 6'(i)) mem[i] <= wr_bit;
                end
                wr_ptr <= wr_ptr + 6'd1;
            end
            if (rd_adv) begin
                mem     <= mem >> GROUP_W;
                grp_ptr <= grp_ptr + 5'd1;
            end
        end
    end

    assign grp_bits = mem[2:0];

endmodule

// File: rtl/candidate_issuer.sv
// rtl/candidate_issuer.sv - loads result bits and issues gapless 3-bit groups; CANDIDATE_ISSUER_LEN_CLAMP_EN enables len clamping with err
module candidate_issuer
    import candidate_pkg::*;
#(
    parameter int MAX_LEN = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [5:0] len,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       en,
    output logic [1:0] reg_mode,
    output logic [5:0] now_0,
    output logic       count,
    output logic       result_0,
    output logic       result_1,
    output logic       result_2,
    output logic       busy,
    output logic       done
`ifdef CANDIDATE_ISSUER_LEN_CLAMP_EN
    ,
    output logic       err
`endif
);

    localparam logic [5:0] MAX_LEN6 = 6'(MAX_LEN);

    state_t     state, state_n;
    logic [5:0] len_q;
    logic [5:0] start_len;
    logic       job_start;
    logic       phase;
    logic [5:0] wr_ptr;
    logic [4:0] grp_ptr;
    logic [2:0] grp_bits;
    logic [5:0] remaining;
`ifdef CANDIDATE_ISSUER_LEN_CLAMP_EN
    logic       clamp_hit;
`endif

    assign remaining = len_q - 6'(grp_ptr) * 6'd3;

    always_comb begin
        state_n   = state;
        job_start = 1'b0;
        start_len = len;
`ifdef CANDIDATE_ISSUER_LEN_CLAMP_EN
        clamp_hit = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len == 6'd0) begin
                        job_start = 1'b1;
                        state_n   = ST_FLUSH;
                    end else if (len > MAX_LEN6) begin
`ifdef CANDIDATE_ISSUER_LEN_CLAMP_EN
                        job_start = 1'b1;
                        start_len = MAX_LEN6;
                        clamp_hit = 1'b1;
                        state_n   = ST_LOAD;
`endif
                    end else begin
                        job_start = 1'b1;
                        state_n   = ST_LOAD;
                    end
                end
            end
            ST_LOAD:  if (in_valid && wr_ptr == len_q - 6'd1) state_n = ST_ISSUE;
            ST_ISSUE: if (remaining <= 6'd3) state_n = ST_FLUSH;
            ST_FLUSH: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            reg_mode <= '0;
            len_q    <= '0;
            phase    <= 1'b0;
`ifdef CANDIDATE_ISSUER_LEN_CLAMP_EN
            err      <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (job_start) begin
                reg_mode <= mode;
                len_q    <= start_len;
                phase    <= 1'b1;
`ifdef CANDIDATE_ISSUER_LEN_CLAMP_EN
                err      <= clamp_hit;
`endif
            end else if (state == ST_ISSUE) begin
                phase <= ~phase;
            end
        end
    end

    issue_bit_buffer #(.MAX_LEN(MAX_LEN)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .clear    (job_start),
        .wr_en    (state == ST_LOAD && in_valid),
        .wr_bit   (in_bit),
        .rd_adv   (state == ST_ISSUE),
        .wr_ptr   (wr_ptr),
        .grp_ptr  (grp_ptr),
        .grp_bits (grp_bits)
    );

    // Outputs decode only registered state, never the inputs.
    assign in_ready = (state == ST_LOAD);
    assign en       = (state == ST_ISSUE) || (state == ST_FLUSH);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_FLUSH);
    assign count    = en & phase;
    assign now_0    = (state == ST_ISSUE) ? group_code(remaining) : NOW_NONE;
    assign result_0 = (state == ST_ISSUE) & grp_bits[0];
    assign result_1 = (state == ST_ISSUE) & grp_bits[1] & (remaining >= 6'd2);
    assign result_2 = (state == ST_ISSUE) & grp_bits[2] & (remaining >= 6'd3);

endmodule

// File: tb/tb_candidate_issuer.sv
// tb/tb_candidate_issuer.sv - randomized scoreboard bench for candidate_issuer
module tb_candidate_issuer;

    localparam int MAXL = 48;

    logic       clk, rst, start, in_valid, in_bit;
    logic [1:0] mode;
    logic [5:0] len;
    logic       in_ready, en, count, result_0, result_1, result_2, busy, done;
    logic [1:0] reg_mode;
    logic [5:0] now_0;
`ifdef CANDIDATE_ISSUER_LEN_CLAMP_EN
    logic       err;
`endif

    candidate_issuer #(.MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .en(en),
        .reg_mode(reg_mode), .now_0(now_0), .count(count),
        .result_0(result_0), .result_1(result_1), .result_2(result_2),
        .busy(busy), .done(done)
`ifdef CANDIDATE_ISSUER_LEN_CLAMP_EN
        , .err(err)
`endif
    );

    typedef struct {
        int r0, r1, r2, now, cnt, dn, md;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   exp_lat = 0;
    bit   done_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every enabled cycle must match the next expected group.
    always @(negedge clk) begin
        if (rst) begin
            if (en) begin
                if (q.size() == 0) begin
                    chk("en_unexpected", en, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("result_0", result_0, mon_e.r0);
                    chk("result_1", result_1, mon_e.r1);
                    chk("result_2", result_2, mon_e.r2);
                    chk("now_0", now_0, mon_e.now);
                    chk("count", count, mon_e.cnt);
                    chk("done", done, mon_e.dn);
                    chk("reg_mode", reg_mode, mon_e.md);
                    if (done) begin
                        done_seen = 1;
                        chk("latency", cyc - start_cyc + 1, exp_lat);
                    end
                end
            end else if (done) begin
                chk("done_without_en", done, 0);
            end
            if (in_ready) chk("ready_en_exclusive", en, 0);
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_en"}, en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_now_0"}, now_0, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_results"}, {result_0, result_1, result_2}, 0);
    endtask

    // Reference model: slice the job into 3-bit groups plus one flush cycle.
    task automatic push_expected(input logic bits[$], input int el, input int md);
        exp_t e;
        int   ng = (el + 2) / 3;
        for (int g = 0; g < ng; g++) begin
            int left = el - 3 * g;
            e.r0  = int'(bits[3*g]);
            e.r1  = (left >= 2) ? int'(bits[3*g+1]) : 0;
            e.r2  = (left >= 3) ? int'(bits[3*g+2]) : 0;
            e.now = (left >= 3) ? 4 : (left == 2) ? 3 : 2;
            e.cnt = (g % 2 == 0) ? 1 : 0;
            e.dn  = 0;
            e.md  = md;
            q.push_back(e);
        end
        e.r0 = 0; e.r1 = 0; e.r2 = 0; e.now = 0; e.dn = 1; e.md = md;
        e.cnt = (ng % 2 == 0) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic run_job(input int m, input int l, input int gap,
                           input bit use_pat, input logic [63:0] pat, input int abort_grp);
        logic bits[$];
        int   el = l;
        bit   accept = 1;
        int   i = 0;
        int   load_cycles = 0;
        if (l > MAXL) begin
`ifdef CANDIDATE_ISSUER_LEN_CLAMP_EN
            el = MAXL;
`else
            accept = 0;
`endif
        end
        for (int k = 0; k < el; k++)
            bits.push_back(use_pat ? pat[k] : logic'($urandom_range(1)));
        done_seen = 0;
        @(posedge clk); #1;
        start = 1'b1; mode = m[1:0]; len = l[5:0]; start_cyc = cyc;
        if (accept) push_expected(bits, el, m);
        @(posedge clk); #1;
        start = 1'b0; mode = 2'($urandom); len = 6'($urandom);
        if (!accept) begin
            repeat (4) begin
                chk("ignored_busy", busy, 0);
                chk("ignored_en", en, 0);
                @(posedge clk); #1;
            end
            return;
        end
`ifdef CANDIDATE_ISSUER_LEN_CLAMP_EN
        chk("err", err, (l > MAXL) ? 1 : 0);
`endif
        while (i < el) begin
            chk("in_ready_load", in_ready, 1);
            in_valid = ($urandom_range(99) >= gap);
            in_bit   = bits[i];
            start    = ($urandom_range(7) == 0);
            @(posedge clk); #1;
            load_cycles++;
            if (in_valid) i++;
        end
        exp_lat  = 2 + load_cycles + (el + 2) / 3;
        in_valid = 1'b0;
        start    = 1'b0;
        chk("in_ready_after_load", in_ready, 0);
        if (abort_grp >= 0) begin
            repeat (abort_grp) @(posedge clk);
            #1 rst = 1'b0;
            #1 check_quiet("abort");
            q.delete();
            @(posedge clk); #1;
            check_quiet("held_reset");
            chk("reg_mode_reset", reg_mode, 0);
            rst = 1'b1;
            return;
        end
        for (int t = 0; t < 200 && !done_seen; t++) @(posedge clk);
        if (!done_seen) chk("done_timeout", 0, 1);
        chk("scoreboard_drained", q.size(), 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mode = '0; len = '0; in_valid = 1'b0; in_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_quiet("reset");
        chk("reset_reg_mode", reg_mode, 0);
        rst = 1'b1;

        run_job(0, 7, 0, 1, 64'h5D, -1);
        run_job(1, 6, 0, 1, 64'h37, -1);
        run_job(2, 0, 0, 0, 64'h0, -1);
        run_job(3, 5, 50, 0, 64'h0, -1);
        run_job(1, 9, 0, 0, 64'h0, 1);
        run_job(2, 8, 0, 0, 64'h0, -1);
        run_job(0, 50, 0, 0, 64'h0, -1);
        run_job(3, 48, 0, 0, 64'h0, -1);
        run_job(2, 1, 0, 0, 64'h0, -1);
        for (int n = 0; n < 25; n++) begin
            int l = ($urandom_range(9) == 0) ? int'($urandom_range(63, 49)) : int'($urandom_range(48));
            run_job(int'($urandom_range(3)), l, int'($urandom_range(60)), 0, 64'h0, -1);
        end
        repeat (3) @(posedge clk);
        #1 check_quiet("final_idle");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/candidate_issuer.md
Name: candidate_issuer

Overview:
- Producer side of the candidate-counting interface: feeds en, reg_mode, now_0, count and result_0/1/2 to the candidate adder.
- Collects a serial stream of result bits into a local buffer, then issues them as back-to-back 3-bit groups.
- The downstream accumulator adds on every cycle while en is high, so groups are issued with no gaps.
- Pulses done on the cycle in which the downstream candidate count is final.

Parameters:
- MAX_LEN, 48: buffer capacity in bits. Must be a multiple of 3 and no more than 63.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- mode  in  2  job mode; latched at start.
- len  in  6  number of bits in the job; latched at start.
- in_valid  in  1  input bit valid.
- in_bit  in  1  input result bit.
- in_ready  out  1  high only in LOAD.
- en  out  1  accumulate enable to the adder.
- reg_mode  out  2  latched mode.
- now_0  out  6  group code: 4 = full group, 3 = two valid bits, 2 = one valid bit, 0 = no group.
- count  out  1  pairing phase for modes 01 and 10.
- result_0  out  1  first bit of the group (oldest).
- result_1  out  1  second bit of the group.
- result_2  out  1  third bit of the group.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, rst=0): state IDLE. All outputs 0 (en, reg_mode, now_0, count, result_*, busy, done, in_ready). Buffer and counters cleared. Reset mid-job aborts the job with no done pulse.
- States: IDLE, LOAD, ISSUE, FLUSH.
- IDLE:
  - On start=1, latch mode into reg_mode and latch len.
  - len=0: go directly to FLUSH.
  - len>MAX_LEN: handling set by the optional feature below.
  - Otherwise go to LOAD.
- LOAD:
  - in_ready=1. A bit is accepted on each cycle with in_valid=1. Accepted bits are stored in arrival order.
  - When the len-th bit is accepted, go to ISSUE on the next edge. in_ready drops in that same cycle.
  - in_valid=0 only stalls LOAD; en stays 0.
- ISSUE:
  - en=1. One group per cycle, ceil(len/3) cycles, with no bubbles.
  - Bits map to result_0, result_1, result_2 in buffer order. Missing bits in the final short group are driven 0.
  - now_0 carries the group code: 4 for a full group; 3 or 2 for the final group when len mod 3 is 2 or 1.
  - count=1 on the first group, then toggles on every group. It is driven identically in all modes; the adder ignores it in modes 00 and 11.
- FLUSH (exactly 1 cycle):
  - en=1, result_*=0, now_0=0, count toggles as in ISSUE, done=1. The downstream candidate is valid in this cycle.
  - Next state IDLE; en falls to 0, which clears the adder.
- start while busy: ignored.
- mode and len changes after start: no effect on the running job.
- Latency from start to done: 1 + len (LOAD with in_valid held high) + ceil(len/3) + 1 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: CANDIDATE_ISSUER_LEN_CLAMP_EN.
- Defined:
  - Adds output err (1 bit). err is cleared at reset and at the next accepted start.
  - A start with len>MAX_LEN is accepted: len is clamped to MAX_LEN and err=1 until the next start.
- Undefined:
  - A start with len>MAX_LEN is ignored; the block stays in IDLE with no done.
  - No err port exists.

Decomposition:
- Shared package candidate_pkg:
  - State enum.
  - GROUP_W=3.
  - now_0 codes NOW_FULL=4, NOW_TWO=3, NOW_ONE=2, NOW_NONE=0.
  - Mode constants MODE_ALL=00, MODE_AND=01, MODE_XOR=10, MODE_MAJ=11.
- One sub-module, issue_bit_buffer, is natural: MAX_LEN-bit write-pointer buffer with a 3-bit group read port and a group read pointer. The FSM and output registers stay in candidate_issuer.

Test Plan:
- Mode 00, len=7, bits 1,0,1,1,1,0,1 → 3 ISSUE cycles: groups 101/110/100 with now_0=4,4,2; count=1,0,1; done in FLUSH; adder candidate=5.
- Mode 01, len=6, bits 1,1,1,0,1,1 → count=1,0; groups 111/011; adder candidate=2 (r0&r1 of the first group, plus r2&prev r2 on the second).
- len=0 → start, then FLUSH with done one cycle later; en high for 1 cycle; adder candidate=0.
- in_valid toggling 1,0 during LOAD for len=5 → en stays 0 until all 5 bits are accepted; ISSUE is then gapless for 2 cycles with now_0=4,3.
- Reset asserted during ISSUE on the 2nd group → all outputs 0 immediately; no done; a fresh start after reset completes correctly.
- len=50 with MAX_LEN=48:
  - Macro defined: 48 bits loaded, 16 groups issued, err=1.
  - Macro undefined: block stays IDLE and busy stays 0.
